multisim_server_stream: RTL
===========================

Name: multisim_server_stream

Overview:
- Parametrised successor to the single-word CPU multisim server. It is a simulation-only bridge that pulls 64-bit words from the multisim server via DPI and packs them into DATA_WIDTH-bit beats.
- Beats are buffered in a FIFO_DEPTH-entry FIFO and presented on a valid/ready stream to the CPU-side consumer.
- Adds three behaviours: prefetch buffering, wide-beat assembly, and a poll backoff after empty server responses.

Parameters:
- DATA_WIDTH, 64, output beat width; must be a multiple of 64, giving WORDS = DATA_WIDTH/64.
- FIFO_DEPTH, 4, number of beat entries; any value >= 1, not required to be a power of two.
- BACKOFF_CYCLES, 0, idle cycles after an empty server response before the next poll; 0 means poll every cycle.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- cpu_index, input, 32, server index; must be stable from reset deassertion onward.
- data_rdy, input, 1, consumer ready.
- data_vld, output, 1, head beat valid.
- data, output, DATA_WIDTH, head beat.
- fifo_level, output, $clog2(FIFO_DEPTH+1), number of occupied entries.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- DPI: uses the existing imports multisim_server_start(idx) and multisim_server_get_data(idx, output bit[63:0] data). A get_data return value with bit0 = 1 means the word is valid.
- Reset values: data_vld = 0, data = 0, fifo_level = 0, word_idx = 0, assembly register = 0, backoff counter = 0.
- FSM states after reset:
  - WAIT_START if the server has never been started.
  - FETCH if it has been started.
  - server_started is a persistent flag and is not cleared by rst_n.
- WAIT_START: on the first posedge with rst_n high, call multisim_server_start(cpu_index) exactly once, set server_started, and go to FETCH. No get_data call happens in that cycle.
- FETCH:
  - Each posedge where the registered fifo_level < FIFO_DEPTH, call get_data(cpu_index) once.
  - If the level is full, make no call and stay in FETCH. Do not fetch speculatively into a slot being freed that same cycle.
  - Valid return:
    - Write the word to assembly slice [64*word_idx +: 64]. Word 0 occupies the LSBs.
    - If word_idx == WORDS-1, push the completed beat (slice included) and set word_idx = 0.
    - Otherwise increment word_idx.
  - Invalid return:
    - If BACKOFF_CYCLES > 0, load the counter with BACKOFF_CYCLES and go to BACKOFF.
    - If BACKOFF_CYCLES == 0, stay in FETCH.
- BACKOFF: no DPI calls. Decrement the counter each cycle; at 1 -> 0, return to FETCH. The first poll occurs exactly BACKOFF_CYCLES+1 cycles after the empty poll. A partial assembly is retained across backoff.
- Output side:
  - data_vld = (fifo_level != 0).
  - data = head entry when valid, else 0.
  - Pop when data_vld && data_rdy.
  - Head is stable while data_vld && !data_rdy.
- Latency: with WORDS = 1 and an empty FIFO, a valid DPI word at posedge N gives data_vld = 1 after N, so the consumer samples it at posedge N+1.
- Simultaneous push and pop: level is unchanged and both are allowed. This includes the full level: no fetch occurs, the pop is honoured, and the level becomes FIFO_DEPTH-1.
- Pointers: read and write pointers wrap from FIFO_DEPTH-1 to 0.
- Overflow: impossible by construction. Add an assertion that there is no push when fifo_level == FIFO_DEPTH.
- Reset mid-operation: FIFO contents and any partial assembly are discarded. Fetched-but-unassembled words are lost; this is documented as intended. No DPI calls occur while rst_n is low.
- Determinism: at most one get_data call per clk edge per instance.

Decomposition:
- Package multisim_server_pkg:
  - WORD_W = 64.
  - typedef enum {WAIT_START, FETCH, BACKOFF} srv_state_t.
  - The DPI import declarations, moved here so every server-side block shares them.
- One sub-module, multisim_sync_fifo, parametrised by width and depth:
  - Push and pop ports, level output, head output.
  - Async active-low reset.
- The top level holds the FSM, assembly register, word_idx, backoff counter and DPI calls.

Test Plan (C stub server with a scripted response queue per index):
- WORDS=1, DEPTH=4, stub returns A,B,C with data_rdy = 1 -> beats A,B,C delivered in order, one per cycle; first data_vld one cycle after the first valid call; start called once with cpu_index = 3.
- DATA_WIDTH=192, stub returns 0x11, 0x22, 0x33 -> single beat {0x33, 0x22, 0x11}; data_vld rises only after the third word.
- DEPTH=2, data_rdy = 0, stub has 5 words -> exactly 2 get_data calls, fifo_level = 2, data stable; raise data_rdy -> remaining 3 delivered, no loss or duplication.
- BACKOFF_CYCLES=3, stub returns empty, then X -> no calls for the 3 following cycles; next call is at +4 and X is delivered.
- DATA_WIDTH=128, reset asserted mid-run between word 0 and word 1 with 2 beats queued -> immediate data_vld = 0, fifo_level = 0; start not re-called; after release the next two words form a fresh beat.
- Full FIFO with simultaneous pop -> level goes to DEPTH-1, no get_data that cycle; fetch resumes the next cycle.

Source files
------------

// File: rtl/multisim_server_pkg.sv
// Shared types and server entry points for the multisim server bridges.
package multisim_server_pkg;

  localparam int unsigned WORD_W = 64;

  typedef enum logic [1:0] {
    WAIT_START,
    FETCH,
    BACKOFF
  } srv_state_t;

  // One scripted server response: vld mirrors bit0 of the get_data return value.
  typedef struct packed {
    logic              vld;
    logic [WORD_W-1:0] word;
  } srv_rsp_t;

  // Server-side state behind the two entry points. Responses are served in order;
  // an exhausted script answers "no data".
  srv_rsp_t    srv_script[$];
  int unsigned srv_start_calls;
  int unsigned srv_get_calls;
  int          srv_last_idx;

  function automatic void multisim_server_start(input int idx);
    srv_start_calls = srv_start_calls + 1;
    srv_last_idx    = idx;
  endfunction

  function automatic int multisim_server_get_data(input int idx, output bit [63:0] data);
    srv_rsp_t rsp;
    srv_get_calls = srv_get_calls + 1;
    srv_last_idx  = idx;
    if (srv_script.size() == 0) begin
      data = '0;
      return 0;
    end
    rsp  = srv_script.pop_front();
    data = rsp.word;
    return rsp.vld ? 1 : 0;
  endfunction

endpackage

// File: rtl/multisim_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and occupancy count.
module multisim_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LvlW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             do_pop;

  assign do_pop = pop && (level_q != '0);
  assign head   = mem[rd_ptr_q];
  assign level  = level_q;

  // Pointer and occupancy update; pointers wrap at DEPTH-1 so any depth works.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      level_q <= level_q + LvlW'(push) - LvlW'(do_pop);
    end
  end

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (level_q == LvlW'(DEPTH))));

endmodule

// File: rtl/multisim_server_stream.sv
// Pulls 64-bit words from the multisim server, packs them into wide beats and
// streams the beats out through a FIFO on a valid/ready interface.
module multisim_server_stream
  import multisim_server_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned BACKOFF_CYCLES = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [31:0]                        cpu_index,
  input  logic                               data_rdy,
  output logic                               data_vld,
  output logic [DATA_WIDTH-1:0]              data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int unsigned WORDS = DATA_WIDTH / WORD_W;
  localparam int unsigned IdxW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CntW  = (BACKOFF_CYCLES > 0) ? $clog2(BACKOFF_CYCLES + 1) : 1;
  localparam int unsigned LvlW  = $clog2(FIFO_DEPTH + 1);

  // Everything the fetch side updates on a clock edge. A completed beat lands in
  // stage_word first because the server answer only exists at the edge itself;
  // the stage counts toward the level and is the head while the FIFO is empty.
  typedef struct packed {
    srv_state_t            state;
    logic [CntW-1:0]       bo_cnt;
    logic [IdxW-1:0]       word_idx;
    logic [DATA_WIDTH-1:0] asm_word;
    logic                  stage_vld;
    logic [DATA_WIDTH-1:0] stage_word;
  } fetch_t;

  fetch_t                fetch_q, fetch_d;
  bit                    server_started;  // survives rst_n: the server is started once
  logic                  start_en, poll_en, pop;
  logic                  fifo_push, fifo_pop, stage_taken;
  logic [DATA_WIDTH-1:0] fifo_head, head;
  logic [LvlW-1:0]       fifo_cnt;

  // One get_data call; applies the answer to the assembly and FSM fields.
  function automatic fetch_t fetch_step(input fetch_t cur, input logic [31:0] idx);
    fetch_t    nxt;
    bit [63:0] word;
    int        rc;
    nxt = cur;
    rc  = multisim_server_get_data(idx, word);
    if (rc[0]) begin
      nxt.asm_word[WORD_W*cur.word_idx +: WORD_W] = word;
      if (cur.word_idx == IdxW'(WORDS - 1)) begin
        nxt.stage_vld  = 1'b1;
        nxt.stage_word = nxt.asm_word;
        nxt.word_idx   = '0;
      end else begin
        nxt.word_idx = cur.word_idx + 1'b1;
      end
    end else if (BACKOFF_CYCLES > 0) begin
      nxt.state  = BACKOFF;
      nxt.bo_cnt = CntW'(BACKOFF_CYCLES);
    end
    return nxt;
  endfunction

  // Output side: the stage is always younger than anything already in the FIFO.
  always_comb begin
    fifo_level  = fifo_cnt + LvlW'(fetch_q.stage_vld);
    data_vld    = (fifo_level != '0);
    head        = (fifo_cnt != '0) ? fifo_head : fetch_q.stage_word;
    data        = data_vld ? head : '0;
    pop         = data_vld && data_rdy;
    stage_taken = pop && (fifo_cnt == '0);
    fifo_pop    = pop && (fifo_cnt != '0);
    fifo_push   = fetch_q.stage_vld && !stage_taken;
    start_en    = (fetch_q.state == WAIT_START);
    poll_en     = (fetch_q.state == FETCH) && (fifo_level < LvlW'(FIFO_DEPTH));
  end

  // Next state when no valid-or-empty answer overrides it.
  always_comb begin
    fetch_d           = fetch_q;
    fetch_d.stage_vld = 1'b0;  // a staged beat always leaves: popped or moved into the FIFO
    unique case (fetch_q.state)
      WAIT_START: fetch_d.state = FETCH;
      FETCH:      fetch_d.state = FETCH;
      BACKOFF: begin
        fetch_d.bo_cnt = fetch_q.bo_cnt - 1'b1;
        if (fetch_q.bo_cnt <= CntW'(1)) begin
          fetch_d.state = FETCH;
        end
      end
      default:    fetch_d.state = FETCH;
    endcase
  end

  // State register; the server calls happen here so each edge makes at most one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q <= '{state: (server_started ? FETCH : WAIT_START), default: '0};
    end else if (start_en) begin
      multisim_server_start(cpu_index);
      server_started <= 1'b1;
      fetch_q        <= fetch_d;
    end else if (poll_en) begin
      fetch_q <= fetch_step(fetch_d, cpu_index);
    end else begin
      fetch_q <= fetch_d;
    end
  end

  multisim_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fetch_q.stage_word),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .level (fifo_cnt)
  );

  level_bound: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_level <= LvlW'(FIFO_DEPTH));

endmodule
